// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single-port memory between instruction fetch and the
// execute-stage load/store port; one transaction in flight, D-side priority with fetch anti-starvation.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_be,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_req_valid,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_be,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic          owner_d_q;   // 1 = data port owns the in-flight transaction
  logic [CW-1:0] starve_cnt;
  logic          d_win;

  // LIMIT==0 makes the compare always false, so fetch wins every tie.
  assign d_win = d_req_valid && (!if_req_valid || (starve_cnt < LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // reset_n qualifies the grants so both readies read 0 while reset is held.
  always_comb begin
    state_d       = state_q;
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset_n && d_win) begin
          d_req_ready = 1'b1;
          state_d     = ISSUE;
        end else if (reset_n && if_req_valid) begin
          if_req_ready = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = mem_req_we ? IDLE : WAIT;
      end
      WAIT: if (mem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_d_q     <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
      starve_cnt    <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= '0;
      d_rsp_valid   <= 1'b0;
      d_rsp_data    <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;

      if (d_req_ready) begin
        owner_d_q     <= 1'b1;
        mem_req_we    <= d_req_we;
        mem_req_addr  <= d_req_addr;
        mem_req_wdata <= d_req_wdata;
        mem_req_be    <= d_req_be;
        if (if_req_valid && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else if (if_req_ready) begin
        owner_d_q     <= 1'b0;
        mem_req_we    <= 1'b0;
        mem_req_addr  <= if_req_addr;
        mem_req_wdata <= '0;
        mem_req_be    <= '0;
        starve_cnt    <= '0;
      end

      // Stores are acked from the request handshake; loads from the memory response.
      if (state_q == ISSUE && mem_req_ready && mem_req_we) begin
        d_rsp_valid <= 1'b1;
        d_rsp_data  <= '0;
      end
      if (state_q == WAIT && mem_rsp_valid) begin
        if (owner_d_q) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= mem_rsp_data;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rsp_data;
        end
      end
    end
  end
endmodule
